// File: rtl/bitserial_div_pkg.sv
// bitserial_pkg: shared FSM state type, default width and counter sizing helper
package bitserial_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int BSDIV_N_DEFAULT = 8;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/bitserial_div_if.sv
// bitserial_div_if: request/result bundle of the bit-serial divider
// master drives start/dividend/divisor; slave returns busy/done/quot/rem (+dz with BSDIV_DIVZERO_EN)
interface bitserial_div_if import bitserial_pkg::*; #(parameter int N = BSDIV_N_DEFAULT) ();
  logic         start;
  logic [2*N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [2*N-1:0] quot;
  logic [N-1:0] rem;
`ifdef BSDIV_DIVZERO_EN
  logic         dz;
  modport master (output start, dividend, divisor, input busy, done, quot, rem, dz);
  modport slave (input start, dividend, divisor, output busy, done, quot, rem, dz);
`else
  modport master (output start, dividend, divisor, input busy, done, quot, rem);
  modport slave (input start, dividend, divisor, output busy, done, quot, rem);
`endif
endinterface

// File: rtl/bitserial_div_step.sv
// bitserial_div_step: one restoring-division step (compare, conditional subtract)
// pr_i: shifted partial remainder, div_i: divisor; pr_o: next remainder, q_o: quotient bit
module bitserial_div_step import bitserial_pkg::*; #(parameter int N = BSDIV_N_DEFAULT) (
  input  logic [N:0]   pr_i,
  input  logic [N-1:0] div_i,
  output logic [N:0]   pr_o,
  output logic         q_o
);
  assign q_o  = pr_i >= {1'b0, div_i};
  assign pr_o = q_o ? pr_i - {1'b0, div_i} : pr_i;
endmodule

// File: rtl/bitserial_div.sv
// bitserial_div: restoring bit-serial divider, 2N/N -> 2N quotient + N remainder, one bit per clock
// clk/rst: clock and sync active-high reset; bus: bitserial_div_if.slave request/result bundle
// BSDIV_DIVZERO_EN: adds dz and a one-cycle shortcut for a zero divisor
module bitserial_div import bitserial_pkg::*; #(parameter int N = BSDIV_N_DEFAULT) (
  input logic clk,
  input logic rst,
  bitserial_div_if.slave bus
);
  localparam int CW = clog2(2*N+1);
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] dvd_q, dvd_d, quot_q, quot_d;
  logic [N-1:0]   dvs_q, dvs_d, rem_q, rem_d;
  logic [N:0]     pr_q, pr_d, pr_sh, pr_nx;
  logic           qb;
`ifdef BSDIV_DIVZERO_EN
  logic           dz_q, dz_d;
  assign bus.dz = dz_q;
`endif
  // dvd_q doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom
  assign pr_sh = (pr_q << 1) | (N+1)'(dvd_q[2*N-1]);
  bitserial_div_step #(.N(N)) u_step (.pr_i(pr_sh), .div_i(dvs_q), .pr_o(pr_nx), .q_o(qb));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef BSDIV_DIVZERO_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = RUN;
        cnt_d   = CW'(2*N);
        dvd_d   = bus.dividend;
        dvs_d   = bus.divisor;
        pr_d    = '0;
`ifdef BSDIV_DIVZERO_EN
        dz_d    = ~|bus.divisor;
        if (dz_d) begin
          state_d = DONE;
          quot_d  = '1;
          rem_d   = bus.dividend[N-1:0];
        end
`endif
      end
      RUN: begin
        pr_d  = pr_nx;
        dvd_d = {dvd_q[2*N-2:0], qb};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quot_d  = {dvd_q[2*N-2:0], qb};
          rem_d   = pr_nx[N-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef BSDIV_DIVZERO_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef BSDIV_DIVZERO_EN
      dz_q    <= dz_d;
`endif
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.quot = quot_q;
  assign bus.rem  = rem_q;
endmodule

// File: tb/tb_bitserial_div.sv
// tb_bitserial_div: vector table, corner sequences and random operands against an arithmetic model
module tb_bitserial_div;
  import bitserial_pkg::*;
  localparam int N = BSDIV_N_DEFAULT;
  localparam int W = 2*N;
  localparam int LAT = W + 1;
`ifdef BSDIV_DIVZERO_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = LAT;
`endif
  typedef struct {
    logic [W-1:0] dd;
    logic [N-1:0] dv;
    logic [W-1:0] q;
    logic [N-1:0] r;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int errs = 0;
  int checks = 0;
  int done_cnt = 0;
  vec_t tbl[5];
  bitserial_div_if #(.N(N)) bus ();
  bitserial_div #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;
  initial begin
    #10000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic go(input logic [W-1:0] dd, input logic [N-1:0] dv);
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.start    = 1'b1;
    cyc(1);
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = N'($urandom);
  endtask
  // lat = index of the done cycle, counting the cycle right after the accept edge as 1
  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 200) begin
      cyc(1);
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
  endtask
  task automatic run_chk(input string nm, input logic [W-1:0] dd, input logic [N-1:0] dv,
                         input logic [W-1:0] q, input logic [N-1:0] r, input int el);
    int lat;
    go(dd, dv);
    wait_done(lat);
    chk($sformatf("%s latency", nm), lat, el);
    chk($sformatf("%s quot", nm), 32'(bus.quot), 32'(q));
    chk($sformatf("%s rem", nm), 32'(bus.rem), 32'(r));
    chk($sformatf("%s busy@done", nm), 32'(bus.busy), 1);
    cyc(1);
    chk($sformatf("%s done pulse", nm), 32'(bus.done), 0);
    chk($sformatf("%s busy idle", nm), 32'(bus.busy), 0);
  endtask
  initial begin
    int lat;
    int base;
    logic [W-1:0] dd;
    logic [N-1:0] dv;
    tbl[0] = '{16'd7224, 8'd56, 16'd129, 8'd0};
    tbl[1] = '{16'd1000, 8'd7, 16'd142, 8'd6};
    tbl[2] = '{16'd65535, 8'd255, 16'd257, 8'd0};
    tbl[3] = '{16'd65535, 8'd1, 16'd65535, 8'd0};
    tbl[4] = '{16'd100, 8'd200, 16'd0, 8'd100};
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    rst = 1'b1;
    cyc(3);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset done", 32'(bus.done), 0);
    chk("reset quot", 32'(bus.quot), 0);
    chk("reset rem", 32'(bus.rem), 0);
`ifdef BSDIV_DIVZERO_EN
    chk("reset dz", 32'(bus.dz), 0);
`endif
    rst = 1'b0;
    cyc(1);
    for (int i = 0; i < 5; i++)
      run_chk($sformatf("vec%0d", i), tbl[i].dd, tbl[i].dv, tbl[i].q, tbl[i].r, LAT);
    bus.dividend = 16'hBEEF;
    bus.divisor = 8'h11;
    cyc(5);
    chk("hold quot", 32'(bus.quot), 0);
    chk("hold rem", 32'(bus.rem), 100);
    go(16'd100, 8'd200);
    wait_done(lat);
    chk("b2b first latency", lat, LAT);
    bus.start = 1'b1;
    bus.dividend = 16'd200;
    bus.divisor = 8'd3;
    cyc(1);
    chk("start in DONE ignored", 32'(bus.busy), 0);
    chk("b2b held rem", 32'(bus.rem), 100);
    cyc(1);
    bus.start = 1'b0;
    chk("b2b accepted", 32'(bus.busy), 1);
    wait_done(lat);
    chk("b2b latency", lat, LAT);
    chk("b2b quot", 32'(bus.quot), 66);
    chk("b2b rem", 32'(bus.rem), 2);
    cyc(1);
    go(16'd1000, 8'd7);
    cyc(4);
    bus.start = 1'b1;
    bus.dividend = 16'd50;
    bus.divisor = 8'd5;
    cyc(2);
    bus.start = 1'b0;
    wait_done(lat);
    chk("midstart latency", lat, LAT - 6);
    chk("midstart quot", 32'(bus.quot), 142);
    chk("midstart rem", 32'(bus.rem), 6);
    cyc(1);
    base = done_cnt;
    cyc(40);
    chk("midstart extra done", done_cnt - base, 0);
    chk("midstart idle", 32'(bus.busy), 0);
    go(16'd7224, 8'd56);
    cyc(4);
    rst = 1'b1;
    cyc(1);
    chk("abort busy", 32'(bus.busy), 0);
    chk("abort done", 32'(bus.done), 0);
    chk("abort quot", 32'(bus.quot), 0);
    chk("abort rem", 32'(bus.rem), 0);
    rst = 1'b0;
    base = done_cnt;
    cyc(30);
    chk("abort no done", done_cnt - base, 0);
    run_chk("divzero", 16'h1234, 8'd0, 16'hFFFF, 8'h34, ZLAT);
`ifdef BSDIV_DIVZERO_EN
    chk("dz set", 32'(bus.dz), 1);
    cyc(3);
    chk("dz held", 32'(bus.dz), 1);
    go(16'd20, 8'd3);
    chk("dz cleared", 32'(bus.dz), 0);
    wait_done(lat);
    chk("after dz quot", 32'(bus.quot), 6);
    chk("after dz rem", 32'(bus.rem), 2);
    cyc(1);
`endif
    for (int i = 0; i < 1000; i++) begin
      dd = W'($urandom);
      dv = N'($urandom_range(1, (1 << N) - 1));
      run_chk($sformatf("rnd%0d", i), dd, dv, dd / W'(dv), N'(dd % W'(dv)), LAT);
      chk($sformatf("rnd%0d identity", i), 32'(bus.quot) * 32'(dv) + 32'(bus.rem), 32'(dd));
      chk($sformatf("rnd%0d rem<dv", i), 32'(bus.rem < dv), 1);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
